// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motor_pkg
// Purpose  : Shared types and helpers for the two-wheel motor command driver:
//            motion command codes, H-bridge direction encodings, driver FSM
//            states and small decode/reversal helper functions.
// Options  : none here; the soft-ramp option MOTOR_RAMP_EN lives in
//            pwm_channel.
// Revision : 1.0 - initial release
// ============================================================================
package motor_pkg;

    // Motion commands from the tracker decode. Codes 5..7 have no meaning
    // and are folded onto STOP by cmd_decode().
    typedef enum logic [2:0] {
        STOP   = 3'd0,
        FOWARD = 3'd1,
        BACK   = 3'd2,
        LEFT   = 3'd3,
        RIGHT  = 3'd4
    } cmd_t;

    // H-bridge {IN1,IN2} encodings
    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_COAST = 2'b00;

    // Driver FSM: RUN drives the wheels, DEAD coasts both wheels before a
    // direction reversal.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DEAD = 1'b1
    } fsm_t;

    function automatic cmd_t cmd_decode(input logic [2:0] raw);
        cmd_t c;
        case (raw)
            3'd1:    c = FOWARD;
            3'd2:    c = BACK;
            3'd3:    c = LEFT;
            3'd4:    c = RIGHT;
            default: c = STOP;
        endcase
        return c;
    endfunction

    // Packed {left_dir, right_dir} for a command. Turning keeps both wheels
    // going forward; only the duty differs.
    function automatic logic [3:0] cmd_dirs(input cmd_t c);
        logic [3:0] d;
        case (c)
            STOP:    d = {DIR_COAST, DIR_COAST};
            BACK:    d = {DIR_REV, DIR_REV};
            default: d = {DIR_FWD, DIR_FWD};
        endcase
        return d;
    endfunction

    // True when a single wheel goes straight from forward to reverse or back.
    function automatic logic wheel_flips(input logic [1:0] cur, input logic [1:0] nxt);
        return ((cur == DIR_FWD) && (nxt == DIR_REV)) ||
               ((cur == DIR_REV) && (nxt == DIR_FWD));
    endfunction

    // True when either wheel of a packed {left,right} pair would reverse.
    function automatic logic dirs_reverse(input logic [3:0] cur, input logic [3:0] nxt);
        return wheel_flips(cur[3:2], nxt[3:2]) || wheel_flips(cur[1:0], nxt[1:0]);
    endfunction

endpackage : motor_pkg
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Purpose  : One wheel's PWM output. Holds the current duty, updates it only
//            on counter wrap (so a period is never cut short or stretched),
//            and compares it against the shared period counter.
// Options  : MOTOR_RAMP_EN - when defined the duty moves toward the target by
//            at most RAMP_STEP per period (drops to 0 are immediate); when not
//            defined the duty jumps straight to the target on wrap.
// Ports    : clk, reset (async, active high)
//            wrap   - shared counter is at its last count this cycle
//            clear  - force duty and output to 0 (dead-time coasting)
//            cnt    - shared period counter
//            target - requested duty (high count per period)
//            pwm    - registered PWM output
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int PWM_PERIOD = 1000,
    parameter int RAMP_STEP  = 100,
    parameter int DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrap,
    input  logic              clear,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] target,
    output logic              pwm
);

    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_next;
    logic              r_pwm;

`ifdef MOTOR_RAMP_EN
    // A step larger than the period cannot be useful; clamping keeps it
    // representable in the duty width.
    localparam int                c_step_int = (RAMP_STEP > PWM_PERIOD) ? PWM_PERIOD : RAMP_STEP;
    localparam logic [DUTY_W-1:0] c_step     = DUTY_W'(c_step_int);

    // Differences are compared against the step before adding/subtracting,
    // so the sum never exceeds the target and cannot wrap.
    always_comb begin
        w_duty_next = target;
        if (target == '0) begin
            w_duty_next = '0;
        end else if (target > r_duty) begin
            if ((target - r_duty) > c_step) begin
                w_duty_next = r_duty + c_step;
            end
        end else if ((r_duty - target) > c_step) begin
            w_duty_next = r_duty - c_step;
        end
    end
`else
    // The ramp step has no role when the duty jumps directly.
    logic [31:0] w_unused_step;
    assign w_unused_step = 32'(RAMP_STEP);

    always_comb begin
        w_duty_next = target;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else if (clear) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            // Duty >= period keeps the compare true for every count.
            r_pwm <= (cnt < r_duty);
            if (wrap) begin
                r_duty <= w_duty_next;
            end
        end
    end

    assign pwm = r_pwm;

endmodule : pwm_channel
`default_nettype wire

// File: rtl/motor_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_driver
// Purpose  : Turns the tracker's 3-bit motion command into H-bridge drive for
//            two wheels: glitch-filtered command acceptance, dead-time coast
//            before any wheel reversal, and period-aligned PWM duty updates.
// Options  : MOTOR_RAMP_EN - soft duty ramp inside pwm_channel.
// Ports    : clk, reset (async, active high)
//            state     [2:0] command 0 STOP, 1 FOWARD, 2 BACK, 3 LEFT,
//                            4 RIGHT, 5..7 STOP
//            left_pwm, right_pwm   wheel enables (PWM)
//            left_dir, right_dir   {IN1,IN2}: 10 fwd, 01 rev, 00 coast
//            busy                  high while coasting before a reversal
// Revision : 1.0 - initial release
// ============================================================================
module motor_cmd_driver
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_FULL   = 900,
    parameter int DUTY_TURN   = 300,
    parameter int CMD_STABLE  = 4,
    parameter int DEAD_CYCLES = 2000,
    parameter int RAMP_STEP   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic       busy
);

    localparam int c_duty_w = $clog2(PWM_PERIOD + 1);
    localparam int c_stab_w = $clog2(CMD_STABLE + 1);
    localparam int c_dead_w = $clog2(DEAD_CYCLES + 1);

    localparam logic [c_duty_w-1:0] c_cnt_last = c_duty_w'(PWM_PERIOD - 1);
    localparam logic [c_duty_w-1:0] c_full     =
        c_duty_w'((DUTY_FULL > PWM_PERIOD) ? PWM_PERIOD : DUTY_FULL);
    localparam logic [c_duty_w-1:0] c_turn     =
        c_duty_w'((DUTY_TURN > PWM_PERIOD) ? PWM_PERIOD : DUTY_TURN);
    localparam logic [c_stab_w-1:0] c_stab_hit = c_stab_w'(CMD_STABLE - 1);
    localparam logic [c_stab_w-1:0] c_stab_max = c_stab_w'(CMD_STABLE);
    localparam logic [c_dead_w-1:0] c_dead_last = c_dead_w'(DEAD_CYCLES - 1);

    // ------------------------------------------------------------------
    // Shared PWM period counter
    // ------------------------------------------------------------------
    logic [c_duty_w-1:0] r_cnt;
    logic                w_wrap;

    assign w_wrap = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command glitch filter. The candidate is loaded on the first cycle a
    // new value is seen; acceptance fires on the cycle the counter would
    // reach CMD_STABLE, i.e. CMD_STABLE+1 cycles after the input changed.
    // The counter then saturates so acceptance fires only once per run.
    // ------------------------------------------------------------------
    cmd_t                w_cmd_in;
    cmd_t                r_cand;
    logic [c_stab_w-1:0] r_stab;
    logic                w_accept;

    assign w_cmd_in = cmd_decode(state);
    assign w_accept = (w_cmd_in == r_cand) && (r_stab == c_stab_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand <= STOP;
            r_stab <= '0;
        end else if (w_cmd_in != r_cand) begin
            r_cand <= w_cmd_in;
            r_stab <= '0;
        end else if (r_stab != c_stab_max) begin
            r_stab <= r_stab + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Driver FSM: state register
    // ------------------------------------------------------------------
    fsm_t                r_fsm,      w_fsm_next;
    cmd_t                r_acc,      w_acc_next;
    logic [3:0]          r_dirs,     w_dirs_next;     // {left, right}
    logic [3:0]          r_pre_dirs, w_pre_next;      // dirs when DEAD began
    logic [c_dead_w-1:0] r_dead_cnt, w_dead_next;
    logic [3:0]          w_cand_dirs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm      <= RUN;
            r_acc      <= STOP;
            r_dirs     <= {DIR_COAST, DIR_COAST};
            r_pre_dirs <= {DIR_COAST, DIR_COAST};
            r_dead_cnt <= '0;
        end else begin
            r_fsm      <= w_fsm_next;
            r_acc      <= w_acc_next;
            r_dirs     <= w_dirs_next;
            r_pre_dirs <= w_pre_next;
            r_dead_cnt <= w_dead_next;
        end
    end

    // ------------------------------------------------------------------
    // Driver FSM: next state. Directions are registered on the same edge
    // the command is accepted, so they appear without extra latency.
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_next  = r_fsm;
        w_acc_next  = r_acc;
        w_dirs_next = r_dirs;
        w_pre_next  = r_pre_dirs;
        w_dead_next = r_dead_cnt;
        w_cand_dirs = cmd_dirs(r_cand);

        case (r_fsm)
            RUN: begin
                if (w_accept) begin
                    w_acc_next = r_cand;
                    if (dirs_reverse(r_dirs, w_cand_dirs)) begin
                        w_fsm_next  = DEAD;
                        w_pre_next  = r_dirs;
                        w_dirs_next = {DIR_COAST, DIR_COAST};
                        w_dead_next = '0;
                    end else begin
                        w_dirs_next = w_cand_dirs;
                    end
                end
            end
            DEAD: begin
                // A later command only retargets; the coast timer keeps
                // running from when DEAD was entered.
                w_dead_next = r_dead_cnt + 1'b1;
                if (w_accept) begin
                    w_acc_next = r_cand;
                end
                // Leave when the coast time is used up, or straight away if
                // the new command no longer reverses relative to the wheels'
                // direction before coasting began.
                if ((w_accept && !dirs_reverse(r_pre_dirs, w_cand_dirs)) ||
                    (r_dead_cnt == c_dead_last)) begin
                    w_fsm_next  = RUN;
                    w_dirs_next = cmd_dirs(w_acc_next);
                    w_dead_next = '0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Target duty per wheel from the accepted command
    // ------------------------------------------------------------------
    logic [c_duty_w-1:0] w_tgt_left;
    logic [c_duty_w-1:0] w_tgt_right;

    always_comb begin
        w_tgt_left  = '0;
        w_tgt_right = '0;
        case (r_acc)
            FOWARD, BACK: begin
                w_tgt_left  = c_full;
                w_tgt_right = c_full;
            end
            LEFT: begin
                w_tgt_left  = c_turn;
                w_tgt_right = c_full;
            end
            RIGHT: begin
                w_tgt_left  = c_full;
                w_tgt_right = c_turn;
            end
            default: begin
                w_tgt_left  = '0;
                w_tgt_right = '0;
            end
        endcase
    end

    // Clearing on the next state (not the current one) keeps PWM low on the
    // very first coasting cycle.
    logic w_pwm_clear;
    assign w_pwm_clear = (w_fsm_next == DEAD);

    pwm_channel #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_STEP  (RAMP_STEP),
        .DUTY_W     (c_duty_w)
    ) u_pwm_left (
        .clk    (clk),
        .reset  (reset),
        .wrap   (w_wrap),
        .clear  (w_pwm_clear),
        .cnt    (r_cnt),
        .target (w_tgt_left),
        .pwm    (left_pwm)
    );

    pwm_channel #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_STEP  (RAMP_STEP),
        .DUTY_W     (c_duty_w)
    ) u_pwm_right (
        .clk    (clk),
        .reset  (reset),
        .wrap   (w_wrap),
        .clear  (w_pwm_clear),
        .cnt    (r_cnt),
        .target (w_tgt_right),
        .pwm    (right_pwm)
    );

    assign left_dir  = r_dirs[3:2];
    assign right_dir = r_dirs[1:0];
    assign busy      = (r_fsm == DEAD);

endmodule : motor_cmd_driver
`default_nettype wire

// File: doc/motor_cmd_driver.md
Name: motor_cmd_driver

Overview:
- Consumes the 3-bit motion command produced by the line-tracker decode logic.
- Drives the two-wheel H-bridge: per-wheel PWM enable plus IN1/IN2 direction pair.
- Adds command glitch filtering, dead-time on wheel reversal, and period-aligned duty updates with optional soft ramp.
- Sits between the tracker decode and the motor pins in the car top level.

Parameters:
- PWM_PERIOD, 1000: PWM period in clk cycles; counter runs 0..PWM_PERIOD-1.
- DUTY_FULL, 900: high-count for the full-speed wheel.
- DUTY_TURN, 300: high-count for the inner wheel while turning.
- CMD_STABLE, 4: cycles a new command must hold before acceptance.
- DEAD_CYCLES, 2000: coast time before reversing any wheel.
- RAMP_STEP, 100: duty increment per PWM period (ramp build only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- state  in  3  command: 0 STOP, 1 FOWARD, 2 BACK, 3 LEFT, 4 RIGHT; 5-7 treated as STOP
- left_pwm  out  1  left wheel enable (PWM)
- right_pwm  out  1  right wheel enable (PWM)
- left_dir  out  2  left {IN1,IN2}: 10 fwd, 01 rev, 00 coast
- right_dir  out  2  right {IN1,IN2}, same encoding
- busy  out  1  high while in DEAD phase

Behaviour:
- Reset (async, immediate): all outputs 0; accepted cmd = STOP; FSM = RUN; counters 0; current duties 0.
- Filter: candidate register plus stability counter.
  - Input differing from candidate reloads candidate and clears the counter.
  - After CMD_STABLE consecutive equal cycles, candidate becomes the accepted cmd.
  - Accept latency = CMD_STABLE+1 cycles from input change.
- Target map, left/right dir and duty:
  - STOP: 00/00, 0/0
  - FOWARD: 10/10, FULL/FULL
  - BACK: 01/01, FULL/FULL
  - LEFT: 10/10, TURN/FULL
  - RIGHT: 10/10, FULL/TURN
- FSM RUN:
  - New accepted cmd with any wheel reversing (10<->01) -> DEAD.
  - Otherwise dirs update in the same cycle as acceptance.
- FSM DEAD:
  - Both dirs 00, both pwm 0, current duties forced 0, busy=1.
  - Counts DEAD_CYCLES, then loads new dirs and returns to RUN.
  - A further accepted cmd during DEAD updates the target only; the timer is not restarted.
  - A cmd needing no reversal from the pre-DEAD dirs may also leave DEAD early, next cycle.
- PWM:
  - Single free-running counter shared by both wheels; wraps PWM_PERIOD-1 -> 0.
  - pwm = (cnt < cur_duty), registered.
  - cur_duty changes only on wrap; no mid-period glitch.
  - Duty 0 gives constant low; duty >= PWM_PERIOD gives constant high.
- Without ramp: cur_duty = target on the next wrap.
- STOP: pwm low on the next wrap, dirs 00 immediately.
- Widths: counter and duty are $clog2(PWM_PERIOD+1) bits; ramp saturates at target, no overflow.

Optional Feature:
- MOTOR_RAMP_EN defined:
  - On each wrap, cur_duty moves toward target by at most RAMP_STEP, up or down.
  - Decreases to 0 (STOP) are immediate.
- Not defined: ramp logic absent; duty jumps to target at the next wrap.

Decomposition:
- Package motor_pkg:
  - Command codes STOP/FOWARD/BACK/LEFT/RIGHT.
  - Dir encodings DIR_FWD=2'b10, DIR_REV=2'b01, DIR_COAST=2'b00.
  - FSM state enum RUN/DEAD.
- Sub-module pwm_channel: duty register, ramp, compare output against the shared counter; instantiated twice.

Test Plan:
- All tests use PWM_PERIOD=16, DUTY_FULL=12, DUTY_TURN=4, CMD_STABLE=4, DEAD_CYCLES=20, RAMP_STEP=4.
- Reset mid-PWM-high (reset pulse while left_pwm=1) -> all outputs 0 in the same cycle; STOP after release.
- STOP->FOWARD (no ramp):
  - dirs 10/10 at cycle 5 after change.
  - From the next wrap, each pwm is high 12 of every 16 cycles.
- Glitch rejection: FOWARD, 3-cycle pulse to LEFT, back to FOWARD -> outputs unchanged, busy never asserted.
- FOWARD->BACK:
  - Both pwm 0, dirs 00, busy=1 for exactly 20 cycles.
  - Then dirs 01/01 and pwm resumes at 12/16.
- LEFT then RIGHT: left/right high-counts 4/12, then 12/4 after the next wrap; no DEAD.
- State=6 -> treated as STOP. With MOTOR_RAMP_EN, a following FOWARD gives high-counts 4, 8, 12, 12 over successive periods.
